// File: rtl/sdvig_pkg.sv
// Shared types and constants for the sdvig_out parallel-in / serial-out shifter.
// Optional build macro used by the top: SDVIG_OUT_AUTO_EN.
package sdvig_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/button_pulse.sv
// Active-low raw button -> two-flop synchronizer -> one-cycle pulse per press.
// No debounce: each clean falling edge of the contact yields one pulse.
module button_pulse (
  input  logic clk,
  input  logic reset,
  input  logic w_button,
  output logic pulse
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~w_button;
      s2 <= s1;
    end
  end

  assign pulse = s1 & ~s2;

endmodule

// File: rtl/sdvig_out.sv
// Board PISO shifter: load a switch word, emit it one bit per step on serial_out.
// Build macro SDVIG_OUT_AUTO_EN adds a prescaler that generates steps every AUTO_DIV clocks.
module sdvig_out
  import sdvig_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEFAULT,
  parameter int unsigned AUTO_DIV = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_button_load,
  input  logic             w_button_step,
  input  logic             dir,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] diod,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] memory;
  logic [CW-1:0]    count;
  logic             dir_q;
  logic             load_p;
  logic             step_p;
  logic             auto_step;
  logic             step_any;
  logic             shift_en;

  button_pulse u_load (
    .clk      (clk),
    .reset    (reset),
    .w_button (w_button_load),
    .pulse    (load_p)
  );

  button_pulse u_step (
    .clk      (clk),
    .reset    (reset),
    .w_button (w_button_step),
    .pulse    (step_p)
  );

`ifdef SDVIG_OUT_AUTO_EN
  localparam int unsigned PW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

  logic [PW-1:0] presc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (load_p || state_q != SHIFT) begin
      presc <= '0;
    end else if (presc == PW'(AUTO_DIV - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign auto_step = (state_q == SHIFT) && (presc == PW'(AUTO_DIV - 1));
`else
  logic auto_div_unused;

  // AUTO_DIV is kept on the interface so both builds share one parameter list.
  assign auto_div_unused = (AUTO_DIV == 0);
  assign auto_step       = 1'b0;
`endif

  // Button and auto step in the same cycle collapse into one step; load always wins.
  assign step_any = step_p | auto_step;
  assign shift_en = step_any && !load_p && (state_q == SHIFT) && (count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_p) begin
      state_d = SHIFT;
    end else if (shift_en && count == CW'(1)) begin
      state_d = DONE;
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memory     <= '0;
      count      <= '0;
      dir_q      <= 1'b0;
      serial_out <= 1'b0;
    end else if (load_p) begin
      memory     <= data_in;
      count      <= CW'(WIDTH);
      dir_q      <= dir;
      serial_out <= 1'b0;
    end else if (shift_en) begin
      count <= count - 1'b1;
      if (dir_q == DIR_MSB) begin
        serial_out <= memory[WIDTH-1];
        memory     <= {memory[WIDTH-2:0], 1'b0};
      end else begin
        serial_out <= memory[0];
        memory     <= {1'b0, memory[WIDTH-1:1]};
      end
    end
  end

  assign diod = memory;

endmodule

// File: tb/tb_sdvig_out.sv
// Self-checking bench for sdvig_out: directed steps plus random load/step traffic
// checked against a word-level reference model (bits shifted so far, by direction).
module tb_sdvig_out;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         w_button_load = 1'b1;
  logic         w_button_step = 1'b1;
  logic         dir = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         serial_out;
  logic [W-1:0] diod;
  logic         busy;
  logic         done;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  logic [W-1:0] m_data = '0;
  logic         m_dir = 1'b0;
  logic         m_loaded = 1'b0;
  int unsigned  m_k = 0;
  logic         m_serial = 1'b0;

  sdvig_out #(
    .WIDTH    (W),
    .AUTO_DIV (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .w_button_load (w_button_load),
    .w_button_step (w_button_step),
    .dir           (dir),
    .data_in       (data_in),
    .serial_out    (serial_out),
    .diod          (diod),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_diod();
    if (!m_loaded) return '0;
    if (m_k >= W) return '0;
    return m_dir ? (m_data >> m_k) : (m_data << m_k);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".serial"}, 32'(serial_out), 32'(m_serial));
    chk({tag, ".diod"}, 32'(diod), 32'(m_diod()));
    chk({tag, ".busy"}, 32'(busy), 32'(m_loaded && m_k < W));
    chk({tag, ".done"}, 32'(done), 32'(m_loaded && m_k == W));
  endtask

  task automatic m_load(input logic [W-1:0] d, input logic dr);
    m_data = d; m_dir = dr; m_loaded = 1'b1; m_k = 0; m_serial = 1'b0;
  endtask

  task automatic m_step();
    if (m_loaded && m_k < W) begin
      m_serial = m_dir ? m_data[m_k] : m_data[W-1-m_k];
      m_k++;
    end
  endtask

  task automatic m_reset();
    m_data = '0; m_dir = 1'b0; m_loaded = 1'b0; m_k = 0; m_serial = 1'b0;
  endtask

  // Press the chosen buttons together for hold cycles; returns after the effect has registered.
  task automatic press(input logic ld, input logic st, input int unsigned hold);
    @(negedge clk);
    if (ld) w_button_load = 1'b0;
    if (st) w_button_step = 1'b0;
    for (int unsigned i = 0; i < hold; i++) @(negedge clk);
    w_button_load = 1'b1;
    w_button_step = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] d, input logic dr);
    data_in = d; dir = dr;
    press(1'b1, 1'b0, 1);
    m_load(d, dr);
  endtask

  task automatic do_step(input int unsigned hold);
    press(1'b0, 1'b1, hold);
    m_step();
  endtask

  initial begin
    logic [7:0] seq_a5;
    seq_a5 = 8'b1010_0101;

    #1 reset = 1'b1;
    #1;
    m_reset();
    check_all("reset_init");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all("idle_after_reset");

`ifdef SDVIG_OUT_AUTO_EN
    data_in = 8'hC3; dir = 1'b0;
    @(negedge clk);
    w_button_load = 1'b0;
    @(negedge clk);
    w_button_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_load(8'hC3, 1'b0);
    check_all("auto_load");
    for (int unsigned i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i % 4 == 0) m_step();
      check_all($sformatf("auto_clk%0d", i));
      if (i == 6) w_button_step = 1'b0;
      if (i == 7) w_button_step = 1'b1;
    end
    chk("auto_done_at_32", 32'(done), 32'd1);
    repeat (8) @(negedge clk);
    check_all("auto_hold_done");
`else
    do_load(8'hA5, 1'b0);
    for (int unsigned i = 0; i < 3; i++) do_step(1);
    check_all("pre_reset_shift");
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    m_reset();
    chk("async_reset.serial", 32'(serial_out), 32'd0);
    chk("async_reset.diod", 32'(diod), 32'd0);
    chk("async_reset.busy", 32'(busy), 32'd0);
    chk("async_reset.done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    do_load(8'hA5, 1'b0);
    check_all("msb_load");
    for (int unsigned i = 0; i < 8; i++) begin
      do_step(1);
      chk($sformatf("msb_seq%0d", i), 32'(serial_out), 32'(seq_a5[7-i]));
      check_all($sformatf("msb_step%0d", i));
    end
    chk("msb_done", 32'(done), 32'd1);
    do_step(1);
    chk("ninth_serial", 32'(serial_out), 32'd1);
    check_all("ninth_step");

    do_load(8'hA5, 1'b1);
    for (int unsigned i = 0; i < 8; i++) begin
      do_step(1);
      chk($sformatf("lsb_seq%0d", i), 32'(serial_out), 32'(seq_a5[7-i]));
      if (i == 0) chk("lsb_diod1", 32'(diod), 32'h52);
      check_all($sformatf("lsb_step%0d", i));
    end

    do_load(8'hF0, 1'b0);
    do_step(1);
    do_step(1);
    chk("f0_diod2", 32'(diod), 32'hC0);
    do_load(8'h0F, 1'b0);
    chk("reload_diod", 32'(diod), 32'h0F);
    chk("reload_busy", 32'(busy), 32'd1);
    for (int unsigned i = 0; i < 8; i++) begin
      do_step(1);
      check_all($sformatf("reload_step%0d", i));
    end

    data_in = 8'h81; dir = 1'b0;
    press(1'b1, 1'b1, 1);
    m_load(8'h81, 1'b0);
    chk("both_diod", 32'(diod), 32'h81);
    check_all("both_pressed");
    do_step(100);
    check_all("held_step");
    repeat (5) @(negedge clk);
    check_all("held_release");

    for (int unsigned n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        do_load(W'($urandom), 1'($urandom));
      end else begin
        data_in = W'($urandom);
        dir = 1'($urandom);
        do_step($urandom_range(1, 4));
      end
      check_all($sformatf("rand%0d", n));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
